spi_ram_cmd: RTL and testbench

- Command-decoding single-port RAM placed directly downstream of the SPI slave.
- Consumes the slave's 10-bit parallel frames (rx_data / rx_valid).
- Executes write-address, write-data, read-address and read-data commands against internal storage.
- Returns read bytes to the slave over tx_data / tx_valid for serial shift-out on MISO.

---
 rtl/spi_ram_cmd.sv | 199 +++++++++++++++++++
 tb/tb_spi_ram_cmd.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_cmd.sv
// ---------------------------------------------------------------------------
// spi_ram_cmd
//
// Command-decoding single-port RAM that sits directly behind an SPI slave.
// The slave hands over 10-bit frames: the top two bits select a command and
// the low byte is the payload. Four commands are understood:
//
//   2'b00 WR_ADDR  load the write address
//   2'b01 WR_DATA  store the payload at the write address
//   2'b10 RD_ADDR  load the read address
//   2'b11 RD_DATA  return mem[read address] on tx_data (payload is a dummy)
//
// rx_valid is a level that can stay high for many cycles while the slave
// holds a frame, so a command runs only on the rising edge of rx_valid.
// Every RD_DATA produces exactly one tx_valid pulse, even when the read is
// rejected, so the slave always has a byte to shift out.
//
// Optional feature (compile-time macro SPI_RAM_AUTO_INC_EN):
//   When defined, a successful WR_DATA / RD_DATA advances its address by one,
//   wrapping from MEM_DEPTH-1 to 0. When undefined, addresses change only
//   through WR_ADDR / RD_ADDR.
//
// Parameters:
//   MEM_DEPTH  number of 8-bit words, 2..256
//   ADDR_SIZE  address width, 2**ADDR_SIZE >= MEM_DEPTH, ADDR_SIZE <= 8
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx_data   frame from the SPI slave, [9:8] command, [7:0] payload
//   rx_valid  frame valid level from the SPI slave
//   tx_data   read-back byte, held until the next RD_DATA
//   tx_valid  one-cycle pulse, tx_data updated
//   seq_err   one-cycle pulse, the accepted command was rejected
// ---------------------------------------------------------------------------
module spi_ram_cmd #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       seq_err
);

    // Command encodings carried in rx_data[9:8].
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Depth widened by one bit so MEM_DEPTH == 2**ADDR_SIZE still fits and
    // the range comparison below is width-matched.
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_vld;
    logic                 rd_addr_vld;
    logic                 rx_valid_q;

    // -----------------------------------------------------------------------
    // Frame decode
    // -----------------------------------------------------------------------
    logic                 accept;
    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic                 addr_ovf;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [ADDR_SIZE-1:0] wr_addr_inc;
    logic [ADDR_SIZE-1:0] rd_addr_inc;

    // One command per frame: only the cycle where rx_valid first rises.
    assign accept  = rx_valid && !rx_valid_q;
    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];

    // An address payload with bits set above the address field cannot be
    // represented and is rejected. With ADDR_SIZE == 8 this is always 0.
    assign addr_ovf = (payload >> ADDR_SIZE) != 8'h00;

    // Non-power-of-two depths leave addresses that exist in the register but
    // not in the array; those are caught here before touching mem.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;

    assign wr_ok = accept && (cmd == CMD_WR_DATA) && wr_addr_vld && wr_in_range;
    assign rd_ok = accept && (cmd == CMD_RD_DATA) && rd_addr_vld && rd_in_range;

    // Wrap at the real depth, not at 2**ADDR_SIZE.
    assign wr_addr_inc = (wr_addr == ADDR_LAST) ? '0 : wr_addr + ADDR_SIZE'(1);
    assign rd_addr_inc = (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_SIZE'(1);

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose; contents survive rst_n
    // and a reset port would stop the array mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= payload;
        end
    end

    // -----------------------------------------------------------------------
    // Control and response
    // -----------------------------------------------------------------------
    // NOTE: every register here is updated with <= so all reads in this block
    // see the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;

            // Pulses default low; an accepted command raises them for one
            // cycle only.
            tx_valid <= 1'b0;
            seq_err  <= 1'b0;

            if (accept) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        if (addr_ovf) begin
                            wr_addr_vld <= 1'b0;
                            seq_err     <= 1'b1;
                        end else begin
                            wr_addr     <= payload[ADDR_SIZE-1:0];
                            wr_addr_vld <= 1'b1;
                        end
                    end

                    CMD_WR_DATA: begin
                        // The array write itself lives in the storage block.
                        if (!wr_ok) begin
                            seq_err <= 1'b1;
                        end else if (AUTO_INC) begin
                            wr_addr <= wr_addr_inc;
                        end
                    end

                    CMD_RD_ADDR: begin
                        if (addr_ovf) begin
                            rd_addr_vld <= 1'b0;
                            seq_err     <= 1'b1;
                        end else begin
                            rd_addr     <= payload[ADDR_SIZE-1:0];
                            rd_addr_vld <= 1'b1;
                        end
                    end

                    CMD_RD_DATA: begin
                        // Always answer so the slave never stalls; a rejected
                        // read answers with zero and flags the error.
                        tx_valid <= 1'b1;
                        if (rd_ok) begin
                            tx_data <= mem[rd_addr];
                            if (AUTO_INC) begin
                                rd_addr <= rd_addr_inc;
                            end
                        end else begin
                            tx_data <= 8'h00;
                            seq_err <= 1'b1;
                        end
                    end

                    default: begin
                        tx_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_cmd.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_cmd
//
// Self-checking bench for spi_ram_cmd. Two instances are exercised: the
// default 256 x 8 configuration and a 16-word, 4-bit-address configuration
// that exposes the address range check. A behavioural model (plain arrays
// and arithmetic, one call per frame) predicts tx_valid, seq_err and tx_data
// for every accepted frame; the bench also checks that held frames produce
// no further pulses and that tx_data holds between reads.
// Honours SPI_RAM_AUTO_INC_EN in the model the same way the design does.
// ---------------------------------------------------------------------------
module tb_spi_ram_cmd;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic [9:0] rx_data0,  rx_data1;
    logic       rx_valid0, rx_valid1;
    logic [7:0] tx_data0,  tx_data1;
    logic       tx_valid0, tx_valid1;
    logic       seq_err0,  seq_err1;

    spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data0),
        .rx_valid (rx_valid0),
        .tx_data  (tx_data0),
        .tx_valid (tx_valid0),
        .seq_err  (seq_err0)
    );

    spi_ram_cmd #(.MEM_DEPTH(16), .ADDR_SIZE(4)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data1),
        .rx_valid (rx_valid1),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .seq_err  (seq_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: per instance, addresses as plain ints, memory as an
    // int array where -1 marks a location never written.
    // -----------------------------------------------------------------------
    int m_mem     [2][256];
    int m_wr_addr [2];
    int m_rd_addr [2];
    bit m_wr_vld  [2];
    bit m_rd_vld  [2];
    int m_last_td [2];

    function automatic int depth(input int s);
        return (s == 0) ? 256 : 16;
    endfunction

    function automatic int asz(input int s);
        return (s == 0) ? 8 : 4;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_wr_addr[s] = 0;
            m_rd_addr[s] = 0;
            m_wr_vld[s]  = 1'b0;
            m_rd_vld[s]  = 1'b0;
            m_last_td[s] = 0;
        end
    endtask

    task automatic model_cmd(input int s, input int cmd, input int pl,
                             output bit etv, output bit ese, output int etd);
        etv = 1'b0;
        ese = 1'b0;
        case (cmd)
            0: begin
                if (pl >= (1 << asz(s))) begin
                    m_wr_vld[s] = 1'b0;
                    ese = 1'b1;
                end else begin
                    m_wr_addr[s] = pl;
                    m_wr_vld[s]  = 1'b1;
                end
            end
            1: begin
                if (m_wr_vld[s] && m_wr_addr[s] < depth(s)) begin
                    m_mem[s][m_wr_addr[s]] = pl;
                    if (AUTO_INC) m_wr_addr[s] = (m_wr_addr[s] + 1) % depth(s);
                end else begin
                    ese = 1'b1;
                end
            end
            2: begin
                if (pl >= (1 << asz(s))) begin
                    m_rd_vld[s] = 1'b0;
                    ese = 1'b1;
                end else begin
                    m_rd_addr[s] = pl;
                    m_rd_vld[s]  = 1'b1;
                end
            end
            default: begin
                etv = 1'b1;
                if (m_rd_vld[s] && m_rd_addr[s] < depth(s)) begin
                    m_last_td[s] = m_mem[s][m_rd_addr[s]];
                    if (AUTO_INC) m_rd_addr[s] = (m_rd_addr[s] + 1) % depth(s);
                end else begin
                    m_last_td[s] = 0;
                    ese = 1'b1;
                end
            end
        endcase
        etd = m_last_td[s];
    endtask

    // -----------------------------------------------------------------------
    // Pin access helpers
    // -----------------------------------------------------------------------
    task automatic drive(input int s, input logic v, input logic [9:0] d);
        if (s == 0) begin
            rx_valid0 = v;
            rx_data0  = d;
        end else begin
            rx_valid1 = v;
            rx_data1  = d;
        end
    endtask

    function automatic logic get_tv(input int s);
        return (s == 0) ? tx_valid0 : tx_valid1;
    endfunction

    function automatic logic get_se(input int s);
        return (s == 0) ? seq_err0 : seq_err1;
    endfunction

    function automatic logic [7:0] get_td(input int s);
        return (s == 0) ? tx_data0 : tx_data1;
    endfunction

    // -----------------------------------------------------------------------
    // One frame: rx_valid high for 'hold' rising edges, then low for 'low'
    // cycles. Outputs are sampled on falling edges.
    // -----------------------------------------------------------------------
    task automatic send_frame(input int s, input int cmd, input int pl,
                              input int hold, input int low);
        bit          etv, ese;
        int          etd;
        int          extra;
        int          drift;
        logic [9:0]  frame;
        logic [31:0] c32;
        logic [31:0] p32;
        c32   = cmd;
        p32   = pl;
        frame = {c32[1:0], p32[7:0]};
        @(negedge clk);
        drive(s, 1'b1, frame);
        model_cmd(s, cmd, pl, etv, ese, etd);
        @(negedge clk);
        check($sformatf("tx_valid i%0d cmd%0d", s, cmd), get_tv(s), etv);
        check($sformatf("seq_err i%0d cmd%0d", s, cmd), get_se(s), ese);
        if (etd >= 0) check($sformatf("tx_data i%0d cmd%0d", s, cmd), get_td(s), etd);
        extra = 0;
        drift = 0;
        for (int i = 1; i < hold + low + 1; i++) begin
            if (i >= hold) drive(s, 1'b0, frame);
            @(negedge clk);
            if (get_tv(s) !== 1'b0 || get_se(s) !== 1'b0) extra++;
            if (m_last_td[s] >= 0 && get_td(s) !== m_last_td[s][7:0]) drift++;
        end
        if (hold > 1) check($sformatf("extra pulses i%0d", s), extra, 0);
        check($sformatf("tx_data hold i%0d", s), drift, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        bit etv, ese;
        int etd;
        int cmd, pl;

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                m_mem[s][a] = -1;
        model_reset();

        rst_n = 1'b0;
        drive(0, 1'b0, 10'h000);
        drive(1, 1'b0, 10'h000);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset tx_data i%0d", s), get_td(s), 8'h00);
            check($sformatf("reset tx_valid i%0d", s), get_tv(s), 1'b0);
            check($sformatf("reset seq_err i%0d", s), get_se(s), 1'b0);
        end
        rst_n = 1'b1;

        // Seed location 0 so the rejected-write check below has known data.
        send_frame(0, 0, 8'h00, 1, 1);
        send_frame(0, 1, 8'h5A, 1, 1);

        // Basic write then read, each frame held four cycles.
        send_frame(0, 0, 8'h05, 4, 2);
        send_frame(0, 1, 8'hA5, 4, 2);
        send_frame(0, 2, 8'h05, 4, 2);
        send_frame(0, 3, 8'h00, 4, 2);

        // Commands before any address after reset are rejected.
        pulse_reset();
        send_frame(0, 3, 8'h00, 2, 1);
        send_frame(0, 1, 8'h3C, 2, 1);
        send_frame(0, 2, 8'h00, 1, 1);
        send_frame(0, 3, 8'h00, 1, 1);

        // Top-of-memory write/read pair (wrap behaviour under auto-increment).
        send_frame(0, 0, 8'hFF, 1, 1);
        send_frame(0, 1, 8'h11, 1, 1);
        send_frame(0, 1, 8'h22, 1, 1);
        send_frame(0, 2, 8'hFF, 1, 1);
        send_frame(0, 3, 8'h00, 1, 1);
        send_frame(0, 3, 8'h00, 1, 1);
        send_frame(0, 2, 8'h00, 1, 1);
        send_frame(0, 3, 8'h00, 1, 1);

        // Small instance: valid access, then an out-of-range read address.
        send_frame(1, 0, 8'h02, 2, 1);
        send_frame(1, 1, 8'h77, 2, 1);
        send_frame(1, 2, 8'h02, 2, 1);
        send_frame(1, 3, 8'h00, 2, 1);
        send_frame(1, 2, 8'h20, 2, 1);
        send_frame(1, 3, 8'h00, 2, 1);

        // Reset while an RD_DATA frame is held high.
        send_frame(0, 0, 8'h03, 1, 1);
        @(negedge clk);
        drive(0, 1'b1, 10'h300);
        model_cmd(0, 3, 0, etv, ese, etd);
        @(posedge clk);
        #1;
        check("pre-reset tx_valid", tx_valid0, etv);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset tx_valid", tx_valid0, 1'b0);
        check("async reset seq_err", seq_err0, 1'b0);
        check("async reset tx_data", tx_data0, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_cmd(0, 3, 0, etv, ese, etd);
        @(negedge clk);
        check("post-reset tx_valid", tx_valid0, etv);
        check("post-reset seq_err", seq_err0, ese);
        check("post-reset tx_data", tx_data0, etd);
        drive(0, 1'b0, 10'h300);
        @(negedge clk);
        check("post-reset single pulse", tx_valid0, 1'b0);

        // Randomized traffic, addresses biased low so reads hit written data.
        for (int n = 0; n < 400; n++) begin
            cmd = $urandom_range(0, 3);
            if (cmd == 0 || cmd == 2)
                pl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            else
                pl = $urandom_range(0, 255);
            send_frame(0, cmd, pl, $urandom_range(1, 4), $urandom_range(0, 2));
        end
        for (int n = 0; n < 200; n++) begin
            cmd = $urandom_range(0, 3);
            pl  = (cmd == 0 || cmd == 2) ? $urandom_range(0, 31) : $urandom_range(0, 255);
            send_frame(1, cmd, pl, $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
